// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED pattern engine.
//   led_mode_e  : pattern selector (shift, bounce, fill, blink)
//   led_state_e : engine FSM state (idle until first enable, then run)
//   LED_MAX     : widest LED bank init_pat can describe
//   init_pat()  : starting pattern for a mode/direction on an n-LED bank
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        LED_SHIFT  = 2'd0,
        LED_BOUNCE = 2'd1,
        LED_FILL   = 2'd2,
        LED_BLINK  = 2'd3
    } led_mode_e;

    typedef enum logic {
        LED_IDLE = 1'b0,
        LED_RUN  = 1'b1
    } led_state_e;

    localparam int LED_MAX = 32;

    // Blink starts fully lit; every other mode starts with one LED at the
    // end the pattern travels away from.  Callers cast the result down to
    // their own bank width.
    function automatic logic [LED_MAX-1:0] init_pat(input led_mode_e mode,
                                                    input logic      dir,
                                                    input int        n);
        logic [LED_MAX-1:0] r;
        for (int i = 0; i < LED_MAX; i++) begin
            if (mode == LED_BLINK) begin
                r[i] = (i < n);
            end else if (dir) begin
                r[i] = (i == n - 1);
            end else begin
                r[i] = (i == 0);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Step prescaler for the LED pattern engine.  Produces a one-cycle tick every
// (CLK_DIV >> speed) enabled cycles.
//   clk    in   system clock
//   rst_n  in   synchronous reset, active low
//   en     in   count enable (engine running and not paused)
//   clr    in   restart the count from zero; suppresses the tick
//   speed  in   period divider exponent
//   tick   out  combinational tick, high in the cycle the period completes
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter int CLK_DIV = 25_000_000,
    parameter int CW      = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   limit;

    // The compare is ">=" against cnt+1 rather than "==" against limit-1 so
    // that a speed-up which leaves the count beyond the new period fires on
    // the next cycle instead of running round the counter, and so that a
    // period that shifts down to zero still ticks every cycle.
    assign limit = 32'(CLK_DIV) >> speed;
    assign tick  = en && !clr && ((32'(cnt_q) + 32'd1) >= limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-mode LED pattern engine with built-in prescaler.
// Optional feature macro: LED_PWM_EN adds a brightness input and a free
// running PWM counter that gates the LED drive.
//   sys_clk     in   system clock
//   sys_rst_n   in   synchronous reset, active low
//   en          in   1 = run, 0 = pause (everything holds)
//   mode        in   0 shift, 1 bounce, 2 fill, 3 blink
//   speed       in   step period = CLK_DIV >> speed cycles
//   dir         in   0 = LSB->MSB, 1 = MSB->LSB, sampled at pattern load
//   brightness  in   duty = brightness / 2^PWM_W (LED_PWM_EN only)
//   LED         out  registered LED drive, 1 = on
//   step        out  one-cycle pulse in the cycle LED shows a new step
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED   = 8,
    parameter int CLK_DIV = 25_000_000,
    parameter int PWM_W   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             dir,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] brightness,
`endif
    output logic [N_LED-1:0] LED,
    output logic             step
);

    led_state_e       state_q, state_d;
    led_mode_e        mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             bdir_q, bdir_d;
    logic [N_LED-1:0] pat_q, pat_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;

    led_mode_e        mode_in;
    logic             mode_chg;
    logic             run_en;
    logic             tick;
    logic [N_LED-1:0] pat_load;
    logic [N_LED-1:0] pat_fill0;
    logic [N_LED-1:0] adv_pat;
    logic             adv_bdir;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;
`else
    localparam logic FULL_ON = (PWM_W > 0);
`endif

    assign mode_in   = led_mode_e'(mode);
    assign mode_chg  = (mode_in != mode_q);
    assign run_en    = (state_q == LED_RUN) && en;
    assign pat_load  = N_LED'(init_pat(mode_in, dir, N_LED));
    assign pat_fill0 = N_LED'(init_pat(LED_FILL, dir_q, N_LED));

    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (run_en),
        .clr   (run_en && mode_chg),
        .speed (speed),
        .tick  (tick)
    );

    // Next pattern for one step of the current mode.  Bounce keeps its own
    // travel flag so each end is shown once before the pattern turns.
    always_comb begin
        adv_pat  = pat_q;
        adv_bdir = bdir_q;
        case (mode_q)
            LED_SHIFT: begin
                adv_pat = dir_q ? {pat_q[0], pat_q[N_LED-1:1]}
                                : {pat_q[N_LED-2:0], pat_q[N_LED-1]};
            end
            LED_BOUNCE: begin
                if (!bdir_q) begin
                    if (pat_q[N_LED-1]) begin
                        adv_pat  = pat_q >> 1;
                        adv_bdir = 1'b1;
                    end else begin
                        adv_pat  = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        adv_pat  = pat_q << 1;
                        adv_bdir = 1'b0;
                    end else begin
                        adv_pat  = pat_q >> 1;
                    end
                end
            end
            LED_FILL: begin
                if (&pat_q) begin
                    adv_pat = pat_fill0;
                end else begin
                    adv_pat = dir_q ? (pat_q | (pat_q >> 1))
                                    : (pat_q | (pat_q << 1));
                end
            end
            default: begin
                adv_pat = ~pat_q;
            end
        endcase
    end

    // Engine FSM.  A mode change reloads without a step pulse and beats a
    // tick landing in the same cycle; a pause holds every register.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        bdir_d  = bdir_q;
        pat_d   = pat_q;
        step_d  = 1'b0;
        case (state_q)
            LED_IDLE: begin
                if (en) begin
                    state_d = LED_RUN;
                    mode_d  = mode_in;
                    dir_d   = dir;
                    bdir_d  = dir;
                    pat_d   = pat_load;
                end
            end
            default: begin
                if (en) begin
                    if (mode_chg) begin
                        mode_d = mode_in;
                        dir_d  = dir;
                        bdir_d = dir;
                        pat_d  = pat_load;
                    end else if (tick) begin
                        pat_d  = adv_pat;
                        bdir_d = adv_bdir;
                        step_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // LED is registered from the next pattern so it lines up with pat_q and
    // with the step pulse; the PWM gate uses the counter value of this cycle.
    always_comb begin
`ifdef LED_PWM_EN
        led_d = pat_d & {N_LED{pwm_cnt_q < brightness}};
`else
        led_d = pat_d & {N_LED{FULL_ON}};
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= LED_IDLE;
            mode_q    <= LED_SHIFT;
            dir_q     <= 1'b0;
            bdir_q    <= 1'b0;
            pat_q     <= '0;
            led_q     <= '0;
            step_q    <= 1'b0;
`ifdef LED_PWM_EN
            pwm_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            bdir_q    <= bdir_d;
            pat_q     <= pat_d;
            led_q     <= led_d;
            step_q    <= step_d;
`ifdef LED_PWM_EN
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
`endif
        end
    end

    assign LED  = led_q;
    assign step = step_q;

endmodule
